// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: merges hazard, memory-wait, MDU, branch and exception
// events into per-register enable/flush strobes and keeps a saturating stall counter.
module pipeline_ctrl #(
   parameter int EXC_DRAIN_CYCLES = 2,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       stall_C,
   input  logic             branch_taken,
   input  logic             exc_req,
   input  logic             mem_access_mem,
   input  logic             dmem_ready,
   input  logic             mdu_start,
   input  logic             mdu_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_exe_en,
   output logic             exe_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_exe_flush,
   output logic             exe_mem_flush,
   output logic             mem_wb_flush,
   output logic             pc_sel_exc,
   output logic             mdu_abort,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   // Hazard code meaning "no stall"; every other code behaves as an EXE stall.
   localparam logic [3:0] NON_STALL = 4'd0;
   localparam int DRAIN_W = $clog2(EXC_DRAIN_CYCLES + 1);

   typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MDU_WAIT = 2'd2, EXC_DRAIN = 2'd3} state_t;

   state_t             state_q, state_n;
   logic [DRAIN_W-1:0] drain_q, drain_n;
   logic               done_lat_q, done_lat_n;
   logic               mem_wait;
   logic               low_rules;

   assign mem_wait = mem_access_mem && !dmem_ready;
   assign state    = state_q;

   always_comb begin
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_exe_en     = 1'b1;
      exe_mem_en    = 1'b1;
      mem_wb_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_exe_flush  = 1'b0;
      exe_mem_flush = 1'b0;
      mem_wb_flush  = 1'b0;
      pc_sel_exc    = 1'b0;
      mdu_abort     = 1'b0;
      state_n       = state_q;
      drain_n       = drain_q;
      done_lat_n    = done_lat_q;
      low_rules     = 1'b0;

      if (rst) begin
         {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en}          = 5'b00000;
         {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush}     = 4'b1111;
         state_n    = RUN;
         drain_n    = '0;
         done_lat_n = 1'b0;
      end else if (exc_req && state_q != EXC_DRAIN) begin
         pc_sel_exc = 1'b1;
         mdu_abort  = (state_q == MDU_WAIT);
         {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush} = 4'b1111;
         state_n    = EXC_DRAIN;
         drain_n    = DRAIN_W'(EXC_DRAIN_CYCLES - 1);
         done_lat_n = 1'b0;
      end else begin
         case (state_q)
            EXC_DRAIN: begin
               pc_en       = 1'b0;
               if_id_flush = 1'b1;
               if (drain_q == '0) state_n = RUN;
               else               drain_n = drain_q - 1'b1;
            end
            MDU_WAIT: begin
               if (mem_wait) begin
                  // MEM stalls under the divider: hold EXE/MEM too, bubble into WB.
                  {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
                  mem_wb_flush = 1'b1;
                  if (mdu_done) done_lat_n = 1'b1;
               end else if (mdu_done || done_lat_q) begin
                  state_n    = RUN;
                  done_lat_n = 1'b0;
                  low_rules  = 1'b1;
               end else begin
                  {pc_en, if_id_en, id_exe_en} = 3'b000;
                  exe_mem_flush = 1'b1;
               end
            end
            default: begin
               if (mem_wait) begin
                  {pc_en, if_id_en, id_exe_en, exe_mem_en} = 4'b0000;
                  mem_wb_flush = 1'b1;
                  state_n      = MEM_WAIT;
               end else if (mdu_start && !mdu_done) begin
                  {pc_en, if_id_en, id_exe_en} = 3'b000;
                  exe_mem_flush = 1'b1;
                  state_n       = MDU_WAIT;
               end else begin
                  state_n   = RUN;
                  low_rules = 1'b1;
               end
            end
         endcase

         if (low_rules) begin
            if (stall_C != NON_STALL) begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_exe_flush = 1'b1;
            end else if (branch_taken) begin
               if_id_flush = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q    <= state_n;
      drain_q    <= drain_n;
      done_lat_q <= done_lat_n;
      if (rst)
         stall_cnt <= '0;
      else if (!pc_en && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with fixed expectations plus
// a randomized run compared against an event-level reference model.
module tb_pipeline_ctrl;

   localparam int N_DRAIN = 2;
   localparam int CW      = 4;
   localparam int CMAX    = 15;

   logic          clk = 1'b0;
   logic          rst, branch_taken, exc_req, mem_access_mem, dmem_ready, mdu_start, mdu_done;
   logic [3:0]    stall_C;
   logic          pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en;
   logic          if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, pc_sel_exc, mdu_abort;
   logic [1:0]    state;
   logic [CW-1:0] stall_cnt;
   logic [10:0]   obs;

   int total = 0;
   int bad   = 0;

   // reference model: pending drain cycles, MDU busy, memory waiting, done seen early
   int   m_drain, m_cnt;
   bit   m_mdu, m_memw, m_lat;
   int   n_drain;
   bit   n_mdu, n_memw, n_lat;
   logic [10:0] e_out;

   localparam logic [10:0] O_RST  = 11'b00000_1111_00;
   localparam logic [10:0] O_DEF  = 11'b11111_0000_00;
   localparam logic [10:0] O_STL  = 11'b00111_0100_00;
   localparam logic [10:0] O_MEMW = 11'b00001_0001_00;
   localparam logic [10:0] O_MDU  = 11'b00011_0010_00;
   localparam logic [10:0] O_EXC  = 11'b11111_1111_11;
   localparam logic [10:0] O_DRN  = 11'b01111_1000_00;

   always #5 clk = ~clk;

   assign obs = {pc_en, if_id_en, id_exe_en, exe_mem_en, mem_wb_en,
                 if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush, pc_sel_exc, mdu_abort};

   pipeline_ctrl #(.EXC_DRAIN_CYCLES(N_DRAIN), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_C(stall_C), .branch_taken(branch_taken), .exc_req(exc_req),
      .mem_access_mem(mem_access_mem), .dmem_ready(dmem_ready), .mdu_start(mdu_start),
      .mdu_done(mdu_done), .pc_en(pc_en), .if_id_en(if_id_en), .id_exe_en(id_exe_en),
      .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
      .id_exe_flush(id_exe_flush), .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
      .pc_sel_exc(pc_sel_exc), .mdu_abort(mdu_abort), .state(state), .stall_cnt(stall_cnt));

   task automatic apply(input logic r, input logic [3:0] sc, input logic br, input logic ex,
                        input logic mem, input logic rdy, input logic ms, input logic md);
      rst = r; stall_C = sc; branch_taken = br; exc_req = ex;
      mem_access_mem = mem; dmem_ready = rdy; mdu_start = ms; mdu_done = md;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      apply(0, 4'd0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic do_reset();
      apply(1, 4'd0, 0, 0, 0, 1, 0, 0);
      tick();
      tick();
      idle();
   endtask

   function automatic logic [10:0] hazard_out(input logic [3:0] sc, input logic br);
      if (sc != 4'd0) return O_STL;
      if (br)         return 11'b11111_1000_00;
      return O_DEF;
   endfunction

   function automatic int exp_state();
      if (m_drain > 0) return 3;
      if (m_mdu)       return 2;
      if (m_memw)      return 1;
      return 0;
   endfunction

   task automatic model_eval();
      bit waiting;
      waiting = mem_access_mem && !dmem_ready;
      n_drain = m_drain; n_mdu = m_mdu; n_memw = m_memw; n_lat = m_lat;
      if (rst) begin
         e_out = O_RST;
         n_drain = 0; n_mdu = 0; n_memw = 0; n_lat = 0;
      end else if (m_drain > 0) begin
         e_out   = O_DRN;
         n_drain = m_drain - 1;
      end else if (exc_req) begin
         e_out = m_mdu ? O_EXC : 11'b11111_1111_10;
         n_drain = N_DRAIN; n_mdu = 0; n_memw = 0; n_lat = 0;
      end else if (m_mdu) begin
         if (waiting) begin
            e_out = O_MEMW;
            n_lat = m_lat || mdu_done;
         end else if (mdu_done || m_lat) begin
            e_out = hazard_out(stall_C, branch_taken);
            n_mdu = 0; n_lat = 0;
         end else begin
            e_out = O_MDU;
         end
      end else if (waiting) begin
         e_out  = O_MEMW;
         n_memw = 1;
      end else if (mdu_start && !mdu_done) begin
         e_out  = O_MDU;
         n_mdu  = 1; n_memw = 0;
      end else begin
         e_out  = hazard_out(stall_C, branch_taken);
         n_memw = 0;
      end
   endtask

   task automatic model_commit();
      if (rst)                          m_cnt = 0;
      else if (!e_out[10] && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_drain = n_drain; m_mdu = n_mdu; m_memw = n_memw; m_lat = n_lat;
   endtask

   task automatic test_reset();
      apply(1, 4'd5, 1, 1, 1, 0, 1, 0);
      total++;
      if (obs !== O_RST) begin bad++; $display("FAIL reset_out1: got %b want %b", obs, O_RST); end
      tick();
      total++;
      if (obs !== O_RST) begin bad++; $display("FAIL reset_out2: got %b want %b", obs, O_RST); end
      total++;
      if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++;
      if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
      tick();
      idle();
      total++;
      if (obs !== O_DEF) begin bad++; $display("FAIL reset_release: got %b want %b", obs, O_DEF); end
      total++;
      if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt_after: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_stall_branch();
      do_reset();
      apply(0, 4'd1, 1, 0, 0, 1, 0, 0);
      total++;
      if (obs !== O_STL) begin bad++; $display("FAIL stall_branch: got %b want %b", obs, O_STL); end
      tick();
      apply(0, 4'd0, 1, 0, 0, 1, 0, 0);
      total++;
      if (obs !== 11'b11111_1000_00) begin bad++; $display("FAIL branch_flush: got %b want 11111100000", obs); end
      total++;
      if (stall_cnt !== 4'd1) begin bad++; $display("FAIL stall_cnt1: got %0d want 1", stall_cnt); end
      tick();
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(0, 4'd0, 0, 0, 1, 0, 0, 0);
         total++;
         if (obs !== O_MEMW) begin bad++; $display("FAIL memwait_out%0d: got %b want %b", i, obs, O_MEMW); end
         tick();
         total++;
         if (state !== 2'd1) begin bad++; $display("FAIL memwait_state%0d: got %0d want 1", i, state); end
      end
      apply(0, 4'd0, 0, 0, 1, 1, 0, 0);
      total++;
      if (obs !== O_DEF) begin bad++; $display("FAIL memwait_release: got %b want %b", obs, O_DEF); end
      tick();
      total++;
      if (state !== 2'd0 || stall_cnt !== 4'd3) begin
         bad++; $display("FAIL memwait_end: got state=%0d cnt=%0d want state=0 cnt=3", state, stall_cnt);
      end
   endtask

   task automatic test_mdu_mem();
      logic [10:0] want [7];
      logic [7:0]  mem_v, rdy_v, ms_v, md_v;
      want  = '{O_MDU, O_MDU, O_MDU, O_MEMW, O_MEMW, O_MEMW, O_DEF};
      mem_v = 8'b0111_1000;
      rdy_v = 8'b1100_0111;
      ms_v  = 8'b0000_0001;
      md_v  = 8'b0001_0000;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         apply(0, 4'd0, 0, 0, mem_v[i], rdy_v[i], ms_v[i], md_v[i]);
         total++;
         if (obs !== want[i]) begin bad++; $display("FAIL mdu_out%0d: got %b want %b", i, obs, want[i]); end
         tick();
         total++;
         if (state !== ((i == 6) ? 2'd0 : 2'd2)) begin
            bad++; $display("FAIL mdu_state%0d: got %0d want %0d", i, state, (i == 6) ? 0 : 2);
         end
      end
   endtask

   task automatic test_exc_mdu();
      do_reset();
      apply(0, 4'd0, 0, 0, 0, 1, 1, 0);
      tick();
      apply(0, 4'd0, 0, 1, 0, 1, 0, 0);
      total++;
      if (obs !== O_EXC) begin bad++; $display("FAIL exc_redirect: got %b want %b", obs, O_EXC); end
      tick();
      for (int i = 0; i < N_DRAIN; i++) begin
         apply(0, 4'd0, 0, (i == 1), 0, 1, 0, 0);
         total++;
         if (obs !== O_DRN || state !== 2'd3) begin
            bad++; $display("FAIL exc_drain%0d: got %b st=%0d want %b st=3", i, obs, state, O_DRN);
         end
         tick();
      end
      idle();
      total++;
      if (obs !== O_DEF || state !== 2'd0) begin
         bad++; $display("FAIL exc_release: got %b st=%0d want %b st=0", obs, state, O_DEF);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(0, 4'd2, 0, 0, 0, 1, 0, 0);
         total++;
         if (stall_cnt !== CW'((i < CMAX) ? i : CMAX)) begin
            bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, stall_cnt, (i < CMAX) ? i : CMAX);
         end
         tick();
      end
      idle();
      total++;
      if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      m_drain = 0; m_mdu = 0; m_memw = 0; m_lat = 0; m_cnt = 0;
      for (int i = 0; i < 600; i++) begin
         apply(($urandom_range(0, 59) == 0),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
         model_eval();
         total++;
         if (obs !== e_out || state !== 2'(exp_state()) || stall_cnt !== CW'(m_cnt)) begin
            bad++;
            $display("FAIL random%0d: got out=%b st=%0d cnt=%0d want out=%b st=%0d cnt=%0d",
                     i, obs, state, stall_cnt, e_out, exp_state(), m_cnt);
         end
         tick();
         model_commit();
      end
   endtask

   initial begin
      test_reset();
      test_stall_branch();
      test_mem_wait();
      test_mdu_mem();
      test_exc_mdu();
      test_saturate();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
